dynamics: RTL and testbench
===========================

Name: dynamics

Overview:
- Per-note amplitude envelope generator in the synth voice path. Sits between the note sequencer and the waveform scaler.
- On `new_note` it latches a target amplitude, note duration, attack rate and decay rate.
- On each `beat` tick it ramps `amplitude_out` up to the target (attack), holds it (sustain), then ramps it down to 0 (decay) once the note duration expires.
- All timing is counted in beats, not clocks.

Parameters:
- AMP_W, 3, width of amplitude_in / amplitude_out
- CNT_W, 6, width of duration / attack / decay and the internal beat counters

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- amplitude_in  input  AMP_W  target (peak) amplitude; latched on new_note
- duration  input  CNT_W  note length in beats, measured from note start; latched on new_note
- attack  input  CNT_W  beats per +1 amplitude step during attack; 0 = jump straight to target; latched on new_note
- decay  input  CNT_W  beats per -1 amplitude step during decay; 0 = drop straight to 0; latched on new_note
- new_note  input  1  single-cycle pulse starting a note
- beat  input  1  single-cycle tempo tick
- amplitude_out  output  AMP_W  current envelope amplitude (registered)

Behaviour:
- Reset (reset=0, async): state IDLE, amplitude_out=0, all counters and latched values 0.
- States: IDLE, ATTACK, SUSTAIN, DECAY. Outputs are registered: a change decided at edge k is visible after edge k.
- Latched registers: tgt, dur, atk, dcy. Counters: note_cnt (beats since note start), step_cnt (beats since last amplitude step).
- Inputs are sampled only on new_note; later input changes do not affect a running note.
- new_note=1, any state:
  - Latch all four inputs; clear note_cnt and step_cnt.
  - If attack=0 or amplitude_in=0: amplitude_out=amplitude_in, state SUSTAIN.
  - Otherwise: amplitude_out=0, state ATTACK.
  - new_note overrides a beat in the same cycle; that beat is ignored.
- beat=1 in IDLE: ignored.
- beat=1 in ATTACK/SUSTAIN:
  - note_cnt+1 computed first.
  - If note_cnt+1 >= dur: enter DECAY with step_cnt=0. Expiry takes precedence over an attack step on the same beat.
  - If dcy=0 on DECAY entry: amplitude_out=0 and state IDLE on that same edge.
  - duration=0 therefore expires on the first beat.
- beat=1 in ATTACK, not expiring:
  - step_cnt+1; when it equals atk, amplitude_out+1 and step_cnt=0.
  - If the new amplitude equals tgt, go to SUSTAIN.
- SUSTAIN: amplitude_out holds at tgt until expiry.
- beat=1 in DECAY:
  - step_cnt+1; when it equals dcy, amplitude_out-1 and step_cnt=0.
  - When amplitude_out reaches 0, go to IDLE.
  - Decay starts from the current level, even if the attack never completed.
- note_cnt saturates at all-ones; there is no wrap-around.
- amplitude_out never exceeds tgt and never underflows below 0.
- beat held high for several cycles counts once per high cycle. Callers must pulse beat for a single cycle.

Decomposition:
- Shared package `dynamics_pkg`:
  - state enum {IDLE, ATTACK, SUSTAIN, DECAY}
  - AMP_W and CNT_W defaults
- One natural sub-module: `beat_step_counter`. A CNT_W counter with clear, advance-on-beat and a "step" pulse when count+1 == rate. Used for both attack and decay pacing.
- Note-duration counting and the FSM stay in the top level.

Test Plan:
Common setup for all scenarios: clk period 10, beat pulsed one cycle every 6 clocks, amplitude_in=4, duration=51.
- Reset: reset=0 mid-note with amplitude_out=3 -> amplitude_out=0 immediately (async), state IDLE; beats afterwards leave the output at 0.
- Attack only: attack=12, decay=0, new_note pulse -> amplitude_out 0→1→2→3→4 at beats 12/24/36/48; holds 4; drops to 0 at beat 51, then IDLE.
- Attack+decay: attack=12, decay=12 -> rise as above to 4; on beat 51 enter DECAY; amplitude_out 3,2,1,0 at beats 63/75/87/99; then IDLE.
- Instant attack: attack=0, decay=12 -> amplitude_out=4 one cycle after new_note; decay steps at beats 63/75/87/99.
- Early expiry: attack=12, duration=30, decay=0 -> amplitude reaches 2 at beat 24; drops to 0 at beat 30 without reaching 4.
- Retrigger and collisions:
  - Retrigger: new_note during SUSTAIN with amplitude_in=6, attack=1 -> output restarts at 0, reaches 6 at beat 6.
  - Collision: new_note coincident with beat -> beat not counted.

Source files
------------

// File: rtl/dynamics_pkg.sv
// Shared types and default widths for the dynamics envelope generator.
package dynamics_pkg;

  localparam int unsigned AMP_W_DEF = 3;
  localparam int unsigned CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    DECAY   = 2'd3
  } state_t;

endpackage

// File: rtl/beat_step_counter.sv
// Beat pacing counter: counts beats since the last amplitude step.
// step_due_c flags that the next advance completes a step (count+1 == rate);
// the caller qualifies it with its own advance condition.
//   clk, reset      : clock, async active-low reset
//   clear           : zero the count (takes precedence over advance)
//   advance         : count one beat
//   rate            : beats per step
//   step_due_c      : combinational, count+1 == rate
import dynamics_pkg::*;

module beat_step_counter #(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] rate,
  output logic             step_due_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W:0]   count_inc;

  // Extra bit so count+1 never wraps onto a small rate.
  assign count_inc  = {1'b0, count_q} + (CNT_W+1)'(1);
  assign step_due_c = (count_inc == {1'b0, rate});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (advance) begin
      count_q <= step_due_c ? '0 : count_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/dynamics.sv
// Per-note amplitude envelope: attack ramp, sustain, decay ramp, paced in beats.
//   clk, reset     : clock, async active-low reset
//   amplitude_in   : target amplitude, latched on new_note
//   duration       : note length in beats, latched on new_note
//   attack         : beats per +1 step (0 = instant), latched on new_note
//   decay          : beats per -1 step (0 = instant), latched on new_note
//   new_note       : start a note (wins over a coincident beat)
//   beat           : tempo tick
//   amplitude_out  : registered envelope amplitude
import dynamics_pkg::*;

module dynamics #(
  parameter int unsigned AMP_W = AMP_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AMP_W-1:0] amplitude_in,
  input  logic [CNT_W-1:0] duration,
  input  logic [CNT_W-1:0] attack,
  input  logic [CNT_W-1:0] decay,
  input  logic             new_note,
  input  logic             beat,
  output logic [AMP_W-1:0] amplitude_out
);

  state_t           state_q, state_n;
  logic [AMP_W-1:0] amp_q, amp_n;
  logic [AMP_W-1:0] tgt_q, tgt_n;
  logic [CNT_W-1:0] dur_q, dur_n;
  logic [CNT_W-1:0] atk_q, atk_n;
  logic [CNT_W-1:0] dcy_q, dcy_n;
  logic [CNT_W-1:0] note_cnt_q, note_cnt_n;

  logic [CNT_W:0]   note_sum;
  logic [CNT_W-1:0] note_sat;
  logic             expire_c;
  logic [AMP_W-1:0] amp_inc, amp_dec;
  logic [CNT_W-1:0] rate_c;
  logic             cnt_clear_c, cnt_adv_c, step_due_c;

  assign amplitude_out = amp_q;

  // Duration check uses the unsaturated sum; the stored count saturates.
  assign note_sum = {1'b0, note_cnt_q} + (CNT_W+1)'(1);
  assign note_sat = note_sum[CNT_W] ? '1 : note_sum[CNT_W-1:0];
  assign expire_c = (note_sum >= {1'b0, dur_q});

  assign amp_inc = amp_q + AMP_W'(1);
  assign amp_dec = amp_q - AMP_W'(1);

  // One pacing counter serves both ramps; it is cleared on every phase change.
  assign rate_c = (state_q == DECAY) ? dcy_q : atk_q;

  beat_step_counter #(.CNT_W(CNT_W)) u_step (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear_c),
    .advance    (cnt_adv_c),
    .rate       (rate_c),
    .step_due_c (step_due_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      amp_q      <= '0;
      tgt_q      <= '0;
      dur_q      <= '0;
      atk_q      <= '0;
      dcy_q      <= '0;
      note_cnt_q <= '0;
    end else begin
      state_q    <= state_n;
      amp_q      <= amp_n;
      tgt_q      <= tgt_n;
      dur_q      <= dur_n;
      atk_q      <= atk_n;
      dcy_q      <= dcy_n;
      note_cnt_q <= note_cnt_n;
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_n     = state_q;
    amp_n       = amp_q;
    tgt_n       = tgt_q;
    dur_n       = dur_q;
    atk_n       = atk_q;
    dcy_n       = dcy_q;
    note_cnt_n  = note_cnt_q;
    cnt_clear_c = 1'b0;
    cnt_adv_c   = 1'b0;

    if (new_note) begin
      tgt_n       = amplitude_in;
      dur_n       = duration;
      atk_n       = attack;
      dcy_n       = decay;
      note_cnt_n  = '0;
      cnt_clear_c = 1'b1;
      if ((attack == '0) || (amplitude_in == '0)) begin
        amp_n   = amplitude_in;
        state_n = SUSTAIN;
      end else begin
        amp_n   = '0;
        state_n = ATTACK;
      end
    end else if (beat) begin
      case (state_q)
        ATTACK, SUSTAIN: begin
          note_cnt_n = note_sat;
          if (expire_c) begin
            cnt_clear_c = 1'b1;
            // Nothing to ramp down: finish immediately.
            if ((dcy_q == '0) || (amp_q == '0)) begin
              amp_n   = '0;
              state_n = IDLE;
            end else begin
              state_n = DECAY;
            end
          end else if (state_q == ATTACK) begin
            cnt_adv_c = 1'b1;
            if (step_due_c) begin
              amp_n = amp_inc;
              if (amp_inc == tgt_q) begin
                state_n = SUSTAIN;
              end
            end
          end
        end
        DECAY: begin
          cnt_adv_c = 1'b1;
          if (step_due_c) begin
            amp_n = amp_dec;
            if (amp_dec == '0) begin
              state_n = IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dynamics.sv
// Directed bench for the dynamics envelope generator.
module tb_dynamics;

  logic       clk;
  logic       reset;
  logic [2:0] amplitude_in;
  logic [5:0] duration;
  logic [5:0] attack;
  logic [5:0] decay;
  logic       new_note;
  logic       beat;
  logic [2:0] amplitude_out;

  int n_checks;
  int n_pass;

  dynamics dut (
    .clk           (clk),
    .reset         (reset),
    .amplitude_in  (amplitude_in),
    .duration      (duration),
    .attack        (attack),
    .decay         (decay),
    .new_note      (new_note),
    .beat          (beat),
    .amplitude_out (amplitude_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse new_note from a negedge; optionally with a coincident beat.
  task automatic start_note(input int a, input int d, input int at, input int dc,
                            input bit with_beat);
    amplitude_in = 3'(a);
    duration     = 6'(d);
    attack       = 6'(at);
    decay        = 6'(dc);
    new_note     = 1'b1;
    beat         = with_beat;
    @(negedge clk);
    new_note     = 1'b0;
    beat         = 1'b0;
  endtask

  // n beats, one high cycle every 6 clocks; ends on a negedge.
  task automatic run_beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  function automatic int amp();
    return int'(amplitude_out);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b0;
    amplitude_in = '0;
    duration     = '0;
    attack       = '0;
    decay        = '0;
    new_note     = 1'b0;
    beat         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_amp", amp(), 0);
    reset = 1'b1;
    @(negedge clk);
    run_beats(2);
    check("idle_beats", amp(), 0);

    // Attack only; later input changes must not disturb the running note
    start_note(4, 51, 12, 0, 1'b0);
    amplitude_in = 3'd7; attack = 6'd1; duration = 6'd2; decay = 6'd5;
    check("atk_start", amp(), 0);
    run_beats(11); check("atk_b11", amp(), 0);
    run_beats(1);  check("atk_b12", amp(), 1);
    run_beats(12); check("atk_b24", amp(), 2);
    run_beats(12); check("atk_b36", amp(), 3);
    run_beats(12); check("atk_b48", amp(), 4);
    run_beats(2);  check("atk_b50", amp(), 4);
    run_beats(1);  check("atk_b51", amp(), 0);
    run_beats(6);  check("atk_idle", amp(), 0);

    // Attack then decay
    start_note(4, 51, 12, 12, 1'b0);
    run_beats(48); check("ad_b48", amp(), 4);
    run_beats(3);  check("ad_b51", amp(), 4);
    run_beats(11); check("ad_b62", amp(), 4);
    run_beats(1);  check("ad_b63", amp(), 3);
    run_beats(12); check("ad_b75", amp(), 2);
    run_beats(12); check("ad_b87", amp(), 1);
    run_beats(12); check("ad_b99", amp(), 0);
    run_beats(12); check("ad_idle", amp(), 0);

    // Instant attack
    start_note(4, 51, 0, 12, 1'b0);
    check("inst_start", amp(), 4);
    run_beats(51); check("inst_b51", amp(), 4);
    run_beats(11); check("inst_b62", amp(), 4);
    run_beats(1);  check("inst_b63", amp(), 3);
    run_beats(36); check("inst_b99", amp(), 0);

    // Early expiry before reaching target
    start_note(4, 30, 12, 0, 1'b0);
    run_beats(24); check("early_b24", amp(), 2);
    run_beats(5);  check("early_b29", amp(), 2);
    run_beats(1);  check("early_b30", amp(), 0);

    // Zero duration expires on the first beat
    start_note(4, 0, 0, 12, 1'b0);
    run_beats(1);  check("dur0_b1", amp(), 4);
    run_beats(12); check("dur0_b13", amp(), 3);

    // Retrigger during sustain
    start_note(4, 51, 0, 0, 1'b0);
    run_beats(3);  check("retrig_sus", amp(), 4);
    start_note(6, 51, 1, 0, 1'b0);
    check("retrig_start", amp(), 0);
    run_beats(1);  check("retrig_b1", amp(), 1);
    run_beats(4);  check("retrig_b5", amp(), 5);
    run_beats(1);  check("retrig_b6", amp(), 6);
    run_beats(3);  check("retrig_hold", amp(), 6);

    // new_note with a coincident beat: that beat is not counted
    start_note(4, 3, 1, 0, 1'b1);
    check("coll_start", amp(), 0);
    run_beats(1);  check("coll_b1", amp(), 1);
    run_beats(1);  check("coll_b2", amp(), 2);
    run_beats(1);  check("coll_b3", amp(), 0);

    // Asynchronous reset mid-note
    start_note(4, 51, 1, 0, 1'b0);
    run_beats(3);  check("rst_pre", amp(), 3);
    #2 reset = 1'b0;
    #1 check("rst_async", amp(), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_beats(5);  check("rst_after", amp(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
